imem_loader: RTL



---
 rtl/imem_loader_pkg.sv | 16 +
 rtl/imem_loader_if.sv | 13 +
 rtl/imem_word_pack.sv | 57 +++++
 rtl/imem_loader.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// Holds the FSM state encoding and the stream/length field widths.
package imem_loader_pkg;

    localparam int BYTE_W = 8;
    localparam int LEN_W  = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEN_LO = 3'd1,
        LEN_HI = 3'd2,
        DATA   = 3'd3,
        CSUM   = 3'd4
    } state_e;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream handshake between the host byte source (master) and the loader (slave).
// A byte moves on every rising clk edge where rx_valid and rx_ready are both 1.
interface imem_loader_if;
    import imem_loader_pkg::*;

    logic [BYTE_W-1:0] rx_data;
    logic              rx_valid;
    logic              rx_ready;

    modport master (output rx_data, output rx_valid, input rx_ready);
    modport slave  (input rx_data, input rx_valid, output rx_ready);

endinterface

// File: rtl/imem_word_pack.sv
// Little-endian byte-to-word assembler: byte k of a word lands in bits [8k+7:8k].
// word_next already contains the byte being accepted, so the caller can register it on the same edge.
module imem_word_pack
    import imem_loader_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              byte_valid,
    input  logic [BYTE_W-1:0] byte_in,
    output logic [WIDTH-1:0]  word_next,
    output logic              word_complete
);

    localparam int BYTES = WIDTH / BYTE_W;
    localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;

    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] asm_q, asm_d;

    always_comb begin
        asm_d         = asm_q;
        idx_d         = idx_q;
        word_complete = 1'b0;
        if (byte_valid) begin
            for (int k = 0; k < BYTES; k++) begin
                if (idx_q == IDX_W'(k)) begin
                    asm_d[k*BYTE_W +: BYTE_W] = byte_in;
                end
            end
            if (idx_q == IDX_W'(BYTES - 1)) begin
                word_complete = 1'b1;
                idx_d         = '0;
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end
        word_next = asm_d;
        if (clear) begin
            idx_d = '0;
            asm_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_q <= '0;
            asm_q <= '0;
        end else begin
            idx_q <= idx_d;
            asm_q <= asm_d;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed byte image into the instruction EBRAM and holds the CPU meanwhile.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing byte making the 8-bit data sum zero.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int   DEPTH     = 512,
    parameter int   DEPTH_LOG = 9,
    parameter int   WIDTH     = 32,
    parameter logic BOOT_HOLD = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    imem_loader_if.slave         rx,
    output logic                 mem_we,
    output logic [DEPTH_LOG-1:0] mem_addr,
    output logic [WIDTH-1:0]     mem_wdata,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic                 cpu_hold,
    output state_e               dbg_state
);

    state_e               state_q, state_d;
    logic [LEN_W-1:0]     len_q, len_d;
    logic [LEN_W-1:0]     word_idx_q, word_idx_d;
    logic                 mem_we_q, mem_we_d;
    logic [DEPTH_LOG-1:0] mem_addr_q, mem_addr_d;
    logic [WIDTH-1:0]     mem_wdata_q, mem_wdata_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 error_q, error_d;
    logic                 cpu_hold_q, cpu_hold_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [BYTE_W-1:0]    sum_q, sum_d;
`endif

    logic                 rx_ready_c;
    logic                 accept;
    logic                 pack_clear;
    logic                 word_complete;
    logic [WIDTH-1:0]     word_next;
    logic [LEN_W-1:0]     len_full;

    always_comb begin
        rx_ready_c = 1'b0;
        case (state_q)
            LEN_LO, LEN_HI, DATA: rx_ready_c = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            CSUM:                 rx_ready_c = 1'b1;
`endif
            default:              rx_ready_c = 1'b0;
        endcase
    end

    assign rx.rx_ready = rx_ready_c;
    assign accept      = rx.rx_valid && rx_ready_c;
    assign len_full    = {rx.rx_data, len_q[BYTE_W-1:0]};

    imem_word_pack #(.WIDTH(WIDTH)) u_pack (
        .clk           (clk),
        .reset         (reset),
        .clear         (pack_clear),
        .byte_valid    (accept && (state_q == DATA)),
        .byte_in       (rx.rx_data),
        .word_next     (word_next),
        .word_complete (word_complete)
    );

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        word_idx_d  = word_idx_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        busy_d      = busy_q;
        done_d      = done_q;
        error_d     = error_q;
        cpu_hold_d  = cpu_hold_q;
        pack_clear  = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        sum_d       = sum_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = LEN_LO;
                    done_d     = 1'b0;
                    error_d    = 1'b0;
                    busy_d     = 1'b1;
                    cpu_hold_d = 1'b1;
                    len_d      = '0;
                    word_idx_d = '0;
                    pack_clear = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    sum_d      = '0;
`endif
                end
            end
            LEN_LO: begin
                if (accept) begin
                    len_d[BYTE_W-1:0] = rx.rx_data;
                    state_d           = LEN_HI;
                end
            end
            LEN_HI: begin
                if (accept) begin
                    len_d = len_full;
                    if (len_full == '0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state_d    = CSUM;
`else
                        state_d    = IDLE;
                        done_d     = 1'b1;
                        busy_d     = 1'b0;
                        cpu_hold_d = 1'b0;
`endif
                    end else if (len_full > LEN_W'(DEPTH)) begin
                        // The core stays held: the memory image is not trustworthy.
                        state_d = IDLE;
                        error_d = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        state_d    = DATA;
                        word_idx_d = '0;
                        pack_clear = 1'b1;
                    end
                end
            end
            DATA: begin
                if (accept) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    sum_d = sum_q + rx.rx_data;
`endif
                    if (word_complete) begin
                        mem_we_d    = 1'b1;
                        mem_addr_d  = word_idx_q[DEPTH_LOG-1:0];
                        mem_wdata_d = word_next;
                        word_idx_d  = word_idx_q + LEN_W'(1);
                        if (word_idx_q == len_q - LEN_W'(1)) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                            state_d    = CSUM;
`else
                            state_d    = IDLE;
                            done_d     = 1'b1;
                            busy_d     = 1'b0;
                            cpu_hold_d = 1'b0;
`endif
                        end
                    end
                end
            end
            CSUM: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                if (accept) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    if (BYTE_W'(sum_q + rx.rx_data) == '0) begin
                        done_d     = 1'b1;
                        cpu_hold_d = 1'b0;
                    end else begin
                        error_d = 1'b1;
                    end
                end
`else
                state_d = IDLE;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            len_q       <= '0;
            word_idx_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            cpu_hold_q  <= BOOT_HOLD;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            word_idx_q  <= word_idx_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
            cpu_hold_q  <= cpu_hold_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_q       <= sum_d;
`endif
        end
    end

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = error_q;
    assign cpu_hold  = cpu_hold_q;
    assign dbg_state = state_q;

endmodule
